// File: rtl/bcd_digit_counter_if.sv
// Control/status bundle for bcd_digit_counter.
// The down signal exists only when BCD_COUNTER_DOWN_EN is defined.
interface bcd_digit_counter_if;
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
`ifdef BCD_COUNTER_DOWN_EN
    logic        down;
`endif
    logic [15:0] digits;
    logic        tick;
    logic        wrap;

    modport master (
        output en, clr, load, load_val,
`ifdef BCD_COUNTER_DOWN_EN
        output down,
`endif
        input  digits, tick, wrap
    );

    modport slave (
        input  en, clr, load, load_val,
`ifdef BCD_COUNTER_DOWN_EN
        input  down,
`endif
        output digits, tick, wrap
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// Four-digit BCD counter (0000-9999) advanced by a programmable prescaler strobe.
// Define BCD_COUNTER_DOWN_EN to add the down input and the decrement path.
module bcd_digit_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    bcd_digit_counter_if.slave        io_bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_p;
    logic [15:0]   r_digits;
    logic          r_tick;
    logic          r_wrap;

    logic [15:0]   w_inc;
    logic          w_inc_wrap;
    logic [15:0]   w_load;

    // Ripple increment: a carry enters digit 0 and propagates through every 9.
    always_comb begin
        logic c;
        c     = 1'b1;
        w_inc = r_digits;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r_digits[i*4 +: 4] == 4'd9) begin
                    w_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_inc[i*4 +: 4] = r_digits[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        w_inc_wrap = c;
    end

    always_comb begin
        w_load = '0;
        for (int i = 0; i < 4; i++)
            w_load[i*4 +: 4] = (io_bus.load_val[i*4 +: 4] > 4'd9) ? 4'd0 : io_bus.load_val[i*4 +: 4];
    end

`ifdef BCD_COUNTER_DOWN_EN
    logic [15:0] w_dec;
    logic        w_dec_wrap;

    always_comb begin
        logic b;
        b     = 1'b1;
        w_dec = r_digits;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r_digits[i*4 +: 4] == 4'd0) begin
                    w_dec[i*4 +: 4] = 4'd9;
                end else begin
                    w_dec[i*4 +: 4] = r_digits[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        w_dec_wrap = b;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p      <= '0;
            r_digits <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (io_bus.clr) begin
            r_p      <= '0;
            r_digits <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (io_bus.load) begin
            r_p      <= '0;
            r_digits <= w_load;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (io_bus.en && r_p == P_LAST) begin
            r_p    <= '0;
            r_tick <= 1'b1;
`ifdef BCD_COUNTER_DOWN_EN
            r_digits <= io_bus.down ? w_dec      : w_inc;
            r_wrap   <= io_bus.down ? w_dec_wrap : w_inc_wrap;
`else
            r_digits <= w_inc;
            r_wrap   <= w_inc_wrap;
`endif
        end else begin
            if (io_bus.en)
                r_p <= r_p + 1'b1;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign io_bus.digits = r_digits;
    assign io_bus.tick   = r_tick;
    assign io_bus.wrap   = r_wrap;
endmodule

// File: tb/tb_bcd_digit_counter.sv
// Randomised + directed bench for bcd_digit_counter against an integer-count model.
// Exercises the down path too when BCD_COUNTER_DOWN_EN is defined.
module tb_bcd_digit_counter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_digit_counter_if bus();

    bcd_digit_counter #(.TICK_DIV(DIV)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: count as a plain integer 0..9999, prescaler as an integer.
    int m_cnt, m_p;
    bit m_tick, m_wrap, m_down;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int r = 0, w = 1;
        for (int i = 0; i < 4; i++) begin
            int d = int'(lv[i*4 +: 4]);
            if (d > 9) d = 0;
            r += d * w;
            w *= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_p = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) model_reset();
        else if (bus.clr) model_reset();
        else if (bus.load) begin
            m_cnt = from_load(bus.load_val); m_p = 0; m_tick = 0; m_wrap = 0;
        end else if (bus.en && m_p == DIV - 1) begin
            m_p = 0; m_tick = 1;
            if (m_down) begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + 9999) % 10000;
            end else begin
                m_wrap = (m_cnt == 9999);
                m_cnt  = (m_cnt + 1) % 10000;
            end
        end else begin
            if (bus.en) m_p++;
            m_tick = 0; m_wrap = 0;
        end
    endtask

    task automatic set_down(input bit d);
        m_down = d;
`ifdef BCD_COUNTER_DOWN_EN
        bus.down = d;
`endif
    endtask

    // One clock: model sees the same inputs as the DUT edge, compare #1 after.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk); #1;
        check({tag, ".digits"}, 32'(bus.digits), 32'(to_bcd(m_cnt)));
        check({tag, ".tick"},   32'(bus.tick),   32'(m_tick));
        check({tag, ".wrap"},   32'(bus.wrap),   32'(m_wrap));
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        set_down(1'b0);
        model_reset();
        #1;
        check("rst.digits", 32'(bus.digits), 32'h0);
        check("rst.tick",   32'(bus.tick),   32'h0);
        check("rst.wrap",   32'(bus.wrap),   32'h0);
        cycles(2, "rst");
        rst_n = 1'b1;

        // 1: first tick 4 edges after release, period 4
        cycles(3, "t1");
        check("t1.pre_tick", 32'(bus.tick), 32'h0);
        cycle("t1");
        check("t1.first_tick", 32'(bus.tick), 32'h1);
        check("t1.first_val",  32'(bus.digits), 32'h0001);
        cycles(8, "t1");
        check("t1.after12", 32'(bus.digits), 32'h0003);

        // 2: 9998 -> 9999 -> 0000 with wrap
        bus.load = 1'b1; bus.load_val = 16'h9998;
        cycle("t2");
        bus.load = 1'b0;
        check("t2.loaded", 32'(bus.digits), 32'h9998);
        cycles(8, "t2");
        check("t2.rollover", 32'(bus.digits), 32'h0000);
        check("t2.tick",     32'(bus.tick),   32'h1);
        check("t2.wrap",     32'(bus.wrap),   32'h1);

        // 3: illegal nibbles forced to 0
        bus.load = 1'b1; bus.load_val = 16'h0A5F;
        cycle("t3");
        bus.load = 1'b0;
        check("t3.sanitised", 32'(bus.digits), 32'h0050);

        // 4: en pause at p=2
        cycles(2, "t4");
        bus.en = 1'b0;
        cycles(10, "t4");
        check("t4.frozen", 32'(bus.digits), 32'h0050);
        bus.en = 1'b1;
        cycle("t4");
        check("t4.no_early_tick", 32'(bus.tick), 32'h0);
        cycle("t4");
        check("t4.resume_tick", 32'(bus.tick), 32'h1);
        check("t4.resume_val",  32'(bus.digits), 32'h0051);

        // 5: clr+load on a step edge, then async reset mid-interval
        cycles(3, "t5");
        bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 16'h1234;
        cycle("t5");
        bus.clr = 1'b0; bus.load = 1'b0;
        check("t5.clr_wins", 32'(bus.digits), 32'h0000);
        check("t5.no_tick",  32'(bus.tick),   32'h0);
        bus.load = 1'b1; bus.load_val = 16'h4321;
        cycle("t5");
        bus.load = 1'b0;
        cycles(2, "t5");
        #2 rst_n = 1'b0;
        #1;
        check("t5.async_digits", 32'(bus.digits), 32'h0);
        check("t5.async_tick",   32'(bus.tick),   32'h0);
        model_reset();
        cycle("t5");
        @(negedge clk) rst_n = 1'b1;
        cycles(5, "t5");

`ifdef BCD_COUNTER_DOWN_EN
        // 6: decrement with borrow and wrap
        set_down(1'b1);
        bus.load = 1'b1; bus.load_val = 16'h0001;
        cycle("t6");
        bus.load = 1'b0;
        cycles(4, "t6");
        check("t6.to_zero", 32'(bus.digits), 32'h0000);
        check("t6.no_wrap", 32'(bus.wrap),   32'h0);
        cycles(4, "t6");
        check("t6.under",   32'(bus.digits), 32'h9999);
        check("t6.wrap",    32'(bus.wrap),   32'h1);
        bus.load = 1'b1; bus.load_val = 16'h1000;
        cycle("t6");
        bus.load = 1'b0;
        cycles(4, "t6");
        check("t6.borrow", 32'(bus.digits), 32'h0999);
        set_down(1'b0);
`endif

        // Random mix of en/clr/load/down, landing near the wrap points often
        for (int i = 0; i < 3000; i++) begin
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.clr  = ($urandom_range(0, 99) == 0);
            bus.load = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       bus.load_val = 16'h9997;
                1:       bus.load_val = 16'h0002;
                default: bus.load_val = 16'($urandom);
            endcase
`ifdef BCD_COUNTER_DOWN_EN
            if ($urandom_range(0, 49) == 0) set_down(~m_down);
`endif
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bcd_digit_counter.md
# bcd_digit_counter

Four-digit BCD event/time counter that feeds the per-digit hex-to-seven-segment decoders on the board display path. A programmable prescaler turns the system clock into a step strobe. Each step advances a 0000–9999 BCD count. The four 4-bit digit outputs connect directly to four seven-segment decoder instances, one nibble per HEX display.

## Interface
- TICK_DIV, default 50000000: clock cycles per count step (1 Hz at 50 MHz); legal range 2..2^26.
- Clock  input  1  system clock; all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low freezes both the prescaler and the count.
- clr  input  1  synchronous clear of the count and prescaler.
- load  input  1  synchronous load of load_val into the count.
- load_val  input  16  four BCD nibbles, [3:0] is the least significant digit.
- down  input  1  count direction, 1 = decrement; present only with the configuration macro.
- digits  output  16  current count, four BCD nibbles, [3:0] = HEX0, [15:12] = HEX3.
- tick  output  1  one-cycle pulse marking a completed step.
- wrap  output  1  one-cycle pulse marking a step that rolled over.

## Operation
- **Prescaler** p counts 0..TICK_DIV-1 while en=1.
  - At p==TICK_DIV-1 with en=1: p returns to 0 and one step occurs on that edge.
  - Width of p is $clog2(TICK_DIV).
- **Per-edge priority:** clr > load > step > hold.
  - clr: digits←0, p←0; tick and wrap stay low. clr acts regardless of en.
  - load: each nibble of load_val is written; a nibble greater than 9 is written as 0. p←0; no tick. load acts regardless of en.
  - step (up): ripple BCD increment. A digit at 9 goes to 0 and carries into the next digit. 9999→0000 asserts wrap.
  - step (down): ripple BCD decrement. A digit at 0 goes to 9 and borrows from the next digit. 0000→9999 asserts wrap.
- en=0: p and digits hold; a step is never lost or skipped across an en pause.
- A step coinciding with clr or load is discarded.
- Digits are always valid BCD (0–9) after reset, clr, load or step.

## Timing
- Reset values: digits=16'h0000, tick=0, wrap=0, p=0. Reset is asynchronous on assertion and takes effect mid-count.
- digits, tick and wrap are registered outputs with no combinational path from inputs.
- The new digits value, tick and wrap all appear in the same cycle, one edge after p==TICK_DIV-1 is sampled with en=1.
- With en held high, tick has a period of exactly TICK_DIV cycles. The first tick arrives TICK_DIV edges after reset release, clr or load.
- A down transition takes effect at the next step only. Mid-interval changes do not disturb p.
- wrap is only ever high in a cycle where tick is high.

## Configuration
- BCD_COUNTER_DOWN_EN defined:
  - The down port exists.
  - Decrement logic is built.
- BCD_COUNTER_DOWN_EN undefined:
  - The down port is absent.
  - The counter only increments.
  - Decrement logic is not synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4.

1. Reset with en=1, then release Resetn: tick first high 4 cycles after release; digits=0001 with it; period 4 cycles. After 12 cycles, digits=0003.
2. load load_val=16'h9998 with en=1: digits=9998 next cycle. After 8 cycles, digits=0000 with tick=1 and wrap=1 in the same cycle.
3. load 16'h0A5F: digits=16'h0050 (both illegal nibbles forced to 0).
4. Drop en for 10 cycles mid-interval at p=2: digits frozen. The next tick arrives 2 cycles after en returns.
5. Assert clr and load together at a step edge: digits=0000, no tick. Assert Resetn low mid-interval: all outputs 0 immediately, without waiting for a clock edge.
6. With BCD_COUNTER_DOWN_EN, down=1, load 16'h0001: 0001→0000 (no wrap), then 0000→9999 with wrap=1. Load 16'h1000: next step gives 0999.
